divrem_iter_unit: RTL
=====================

Name: divrem_iter_unit

Overview:
- Parametrised iterative integer divide/remainder unit for the multiply/divide path of the Ibex-based core.
- Successor to the fixed 32-bit remainder-only FSM: configurable width, all four RISC-V divide ops, quotient and remainder both returned.
- Uses a valid/ready request handshake, a held result with acknowledge, and kill support.
- Restoring division, one quotient bit per cycle, self-contained subtractor; no shared ALU adder.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset, sampled on the clk_i rising edge.
- req_i  in  1  request valid.
- ready_o  out  1  unit can accept a request; high only in IDLE.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_a_i  in  WIDTH  dividend; sampled at accept only.
- op_b_i  in  WIDTH  divisor; sampled at accept only.
- kill_i  in  1  abort the in-flight operation.
- valid_o  out  1  result valid; held until acknowledged.
- ack_i  in  1  consumer takes the result.
- result_o  out  WIDTH  quotient for DIV/DIVU, remainder for REM/REMU.
- quotient_o  out  WIDTH  signed-corrected quotient.
- remainder_o  out  WIDTH  signed-corrected remainder.
- div_by_zero_o  out  1  result came from a zero divisor; qualified by valid_o.

Behaviour:
- Reset: synchronous; when rst_ni is low at a clock edge, the FSM goes to IDLE. All outputs are 0 except ready_o=1. Reset mid-operation discards all state and produces no valid_o.
- Accept: when req_i & ready_o are high at a clock edge, capture op_a, op_b and op. Signed mode is active for op_i[0]==0.
- States:
  - IDLE -> ABS on accept.
  - ABS: compute |a| and |b|; record neg_q = sa^sb and neg_r = sa, where sx is the MSB in signed mode and 0 otherwise. If b==0, go to DONE with q=all-ones, r=a, div_by_zero=1. Otherwise go to COMP with the counter loaded to WIDTH-1.
  - COMP: shift the next dividend bit into the partial remainder; trial-subtract |b| using a WIDTH+1-bit difference. A non-negative difference sets the quotient bit and keeps the difference as the new partial remainder. Decrement the counter; go to SIGN after the iteration with counter==0.
  - SIGN: q = neg_q ? -q : q; r = neg_r ? -r : r, all two's complement mod 2^WIDTH. Go to DONE.
  - DONE: valid_o=1, outputs stable. Go to IDLE on ack_i; ready_o rises the next cycle, so there is no same-cycle re-accept.
- Latency (accept edge = cycle 0):
  - Normal operation: valid_o high in cycle WIDTH+3.
  - Divide by zero: valid_o high in cycle 2.
- Overflow, signed MIN / -1: q=MIN, r=0. Falls out of the algorithm (|MIN| is treated as unsigned); no special case.
- Signed zero remainder is never negated to nonzero (-0 = 0).
- kill_i: in any non-IDLE state, the FSM goes to IDLE at the next edge, valid_o stays 0, results are discarded. kill_i in IDLE has no effect. If kill_i and ack_i are both high in DONE, the result goes to IDLE; the consumer must not count it as delivered.
- req_i while busy: ignored, no queuing.
- Outputs are registered; no combinational path from inputs to outputs except none (ready_o is state-decoded).

Optional Feature:
- Macro: DIVREM_LZC_SKIP_EN.
- Defined:
  - ABS also computes the leading-zero count of |a| and loads the counter with msb_index(|a|); |a|==0 loads 0.
  - The partial remainder starts at 0, and the skipped leading bits are zero.
  - COMP runs msb_index+1 cycles, minimum 1.
  - Latency is msb_index(|a|)+4; divide by zero is still 2.
  - Results are identical to the non-skip build.
- Undefined: COMP always runs WIDTH cycles and there is no LZC logic.

Test Plan:
- WIDTH=32, DIVU a=100 b=7 -> quotient_o=14, remainder_o=2, result_o=14; valid_o exactly at accept+35, ready_o=0 throughout.
- DIV a=-7 (0xFFFFFFF9) b=2 -> result_o=0xFFFFFFFD. REM with the same operands -> result_o=0xFFFFFFFF. REMU a=7 b=0xFFFFFFFE -> 7.
- DIV a=5 b=0 -> result_o=0xFFFFFFFF, div_by_zero_o=1, valid at accept+2. REMU a=5 b=0 -> 5.
- DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0, div_by_zero_o=0.
- Hold ack_i=0 for 10 cycles in DONE -> valid_o, result_o and ready_o=0 stable; req_i ignored.
- kill_i in cycle 10 of COMP -> ready_o=1 next cycle, no valid_o pulse.
- Deassert rst_ni mid-COMP -> IDLE outputs next edge.
- With DIVREM_LZC_SKIP_EN: DIVU a=3 b=1 -> q=3, r=0, valid at accept+5; a=0 b=9 -> q=0, r=0, valid at accept+4. Without the macro, both take accept+35.

Source files
------------

// File: rtl/divrem_iter_unit.sv
// Iterative restoring divide/remainder unit (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional DIVREM_LZC_SKIP_EN: start iterating at the dividend's leading one to skip zero bits.
module divrem_iter_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_COMP, S_SIGN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               dbz_q, dbz_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   res_out_q, res_out_d;
    logic [WIDTH-1:0]   quo_out_q, quo_out_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;
    logic               dbz_out_q, dbz_out_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     part, diff;

    // Signed mode is op[0]==0; |MIN| stays 2^(WIDTH-1) read as unsigned.
    assign sgn_a = ~op_q[0] & a_q[WIDTH-1];
    assign sgn_b = ~op_q[0] & b_q[WIDTH-1];
    assign abs_a = sgn_a ? ('0 - a_q) : a_q;
    assign abs_b = sgn_b ? ('0 - b_q) : b_q;
    assign part  = {rem_q, a_q[cnt_q]};
    assign diff  = part - {1'b0, b_q};

`ifdef DIVREM_LZC_SKIP_EN
    logic [CNT_W-1:0] msb_idx;
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) msb_idx = CNT_W'(i);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d    = op_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    dbz_d   = 1'b0;
                    state_d = S_ABS;
                end
            end
            S_ABS: begin
                negq_d = sgn_a ^ sgn_b;
                negr_d = sgn_a;
                if (b_q == '0) begin
                    quo_d   = '1;
                    rem_d   = a_q;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d     = abs_a;
                    b_d     = abs_b;
                    quo_d   = '0;
                    rem_d   = '0;
`ifdef DIVREM_LZC_SKIP_EN
                    cnt_d   = msb_idx;
`else
                    cnt_d   = CNT_W'(WIDTH - 1);
`endif
                    state_d = S_COMP;
                end
            end
            S_COMP: begin
                // Bit cnt_q of the dividend enters; quotient bit lands at the same index.
                if (!diff[WIDTH]) begin
                    rem_d        = diff[WIDTH-1:0];
                    quo_d[cnt_q] = 1'b1;
                end else begin
                    rem_d        = part[WIDTH-1:0];
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_SIGN;
            end
            S_SIGN: begin
                quo_d   = negq_q ? ('0 - quo_q) : quo_q;
                rem_d   = negr_q ? ('0 - rem_q) : rem_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (valid_q && ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill_i && state_q != S_IDLE) state_d = S_IDLE;

        // Result registers publish one cycle after DONE is entered and clear on leave.
        valid_d   = (state_q == S_DONE) && (state_d == S_DONE);
        quo_out_d = valid_d ? quo_q : '0;
        rem_out_d = valid_d ? rem_q : '0;
        res_out_d = valid_d ? (op_q[1] ? rem_q : quo_q) : '0;
        dbz_out_d = valid_d & dbz_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            dbz_q     <= 1'b0;
            valid_q   <= 1'b0;
            res_out_q <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            dbz_q     <= dbz_d;
            valid_q   <= valid_d;
            res_out_q <= res_out_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign valid_o       = valid_q;
    assign result_o      = res_out_q;
    assign quotient_o    = quo_out_q;
    assign remainder_o   = rem_out_q;
    assign div_by_zero_o = dbz_out_q;

endmodule
